risc16_bus_resp: RTL and testbench
==================================

Name: risc16_bus_resp

Overview:
Memory and I/O responder on the far side of the RISC16 core's instruction and data buses.
- Serves instruction fetches and data loads/stores, including byte stores, from a shared word RAM.
- Decodes a memory-mapped I/O page containing:
  - UART transmitter with a 1-entry holding buffer
  - free-running cycle counter
  - halt/result register for testbenches
- A preload port lets the bench write the program image before releasing the core.

Parameters:
MEM_AW, 14, RAM word-address width (2^MEM_AW 16-bit words); byte address bits [MEM_AW:1] index RAM, upper bits alias.
IO_BASE, 16'hFF00, base byte address of the 256-byte I/O page (daddr[15:8] == IO_BASE[15:8]).
UART_DIV, 16, clocks per UART bit; legal range >= 2.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
iaddr  in  16  instruction byte address from core
ioe  in  1  instruction output enable
idin  out  16  instruction word to core, combinational
daddr  in  16  data byte address from core
doe  in  1  data read enable
dwe0  in  1  write enable, byte at even address = ddout[15:8]
dwe1  in  1  write enable, byte at odd address = ddout[7:0]
ddout  in  16  write data from core
ddin  out  16  read data to core, combinational
pl_we  in  1  preload write strobe
pl_addr  in  MEM_AW  preload word address
pl_data  in  16  preload word
tx  out  1  UART serial out, idle high
halt  out  1  sticky halt flag
halt_code  out  16  word written to HALT register

Behaviour:
- Byte order is big-endian: even byte = bits [15:8]. Word index = addr[MEM_AW:1]. daddr[0] is ignored for the word select; lane choice comes from dwe0/dwe1.
- Reads are combinational, zero latency. The core samples ddin/idin in the same cycle it presents the address.
- idin:
  - = RAM[iaddr] when ioe=1 and iaddr is outside the I/O page.
  - = 16'h0000 (NOP) when ioe=0 or iaddr is in the I/O page.
- ddin:
  - doe=1, RAM region: RAM word.
  - doe=1, I/O page: I/O register value.
  - doe=0: 16'h0000.
- RAM writes on the clock edge; dwe0/dwe1 enable their byte lanes independently. Reading a location in the same cycle it is written returns the old contents.
- pl_we has priority over a CPU write to any RAM word in the same cycle; the CPU write is dropped entirely.
- RAM is not cleared by rst.
- I/O registers (offset from IO_BASE). A write is any of dwe0/dwe1; I/O writes use the full ddout regardless of lane.
  - 0x00 UART_DATA: write offers ddout[7:0] to the transmitter; reads 0.
  - 0x02 UART_STAT: read {13'b0, ovf, hold_full, busy}; any write clears ovf.
  - 0x04 CYCLE: read 16-bit counter. It increments every cycle and wraps FFFF->0000. A write loads ddout, and the counter increments from that value on the next cycle.
  - 0x06 HALT: write sets halt=1 and halt_code=ddout. halt stays set until rst; later writes update halt_code only. Reads return halt_code.
  - Other offsets: read 0, writes ignored.
- UART FSM, 8N1, LSB first, each bit held UART_DIV clocks. States: IDLE, START, DATA, STOP.
  - IDLE: on UART_DATA write, load the shifter and enter START next cycle (tx=0). busy=1 in all non-IDLE states.
  - DATA: 8 bits with a bit counter 0..7. STOP: tx=1 for UART_DIV clocks.
  - End of STOP with hold_full=1: move hold to shifter, clear hold_full, go directly to START.
  - End of STOP with hold_full=0: go to IDLE.
  - Write while busy with hold_full=0: hold <= byte, hold_full=1.
  - Write while busy with hold_full=1: byte dropped, ovf=1.
  - Write in the same cycle STOP ends with hold_full=1: the old hold is transferred, the new byte enters hold, ovf unchanged.
- Reset state, asynchronous: tx=1, FSM IDLE, hold_full=0, ovf=0, CYCLE=0, halt=0, halt_code=0. Reset mid-frame aborts the frame immediately (tx=1).

Test Plan:
- Preload word 0x1234 at word 5, then read with daddr=0x000A, doe=1 -> ddin=0x1234 in the same cycle; ioe=1, iaddr=0x000A -> idin=0x1234.
- Byte store: daddr=0x000B, dwe1=1, ddout=0x00AB on word 0x1234 -> word becomes 0x12AB. Then daddr=0x000A, dwe0=1, ddout=0xCD00 -> 0xCDAB.
- UART_DIV=4, write 0x55 to 0xFF00 -> tx low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; STAT busy=1 throughout, then 0.
- Write 0x41, 0x42, 0x43 back-to-back while idle -> 0x41 sent; 0x42 held (STAT=0x3); 0x43 dropped (ovf: STAT=0x7); 0x42 follows 0x41 with no idle gap; a write to STAT clears ovf.
- Write 0xFFFE to CYCLE -> reads of consecutive cycles give 0xFFFF, 0x0000, 0x0001.
- Write 0xBEEF to 0xFF06 -> halt=1, halt_code=0xBEEF. Assert rst mid-UART-frame -> tx=1, halt=0 immediately without waiting for clk; RAM contents preserved.

Source files
------------

// File: rtl/risc16_bus_resp.sv
`default_nettype none
// ============================================================================
//  Module      : risc16_bus_resp
//  Description : RISC16 memory/I-O responder: shared word RAM for instruction
//                and data buses, memory-mapped UART TX, cycle counter, halt.
//  Revision    : 1.0  initial release
// ============================================================================
module risc16_bus_resp #(
    parameter int          MEM_AW   = 14,
    parameter logic [15:0] IO_BASE  = 16'hFF00,
    parameter int          UART_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       iaddr,
    input  logic              ioe,
    output logic [15:0]       idin,
    input  logic [15:0]       daddr,
    input  logic              doe,
    input  logic              dwe0,
    input  logic              dwe1,
    input  logic [15:0]       ddout,
    output logic [15:0]       ddin,
    input  logic              pl_we,
    input  logic [MEM_AW-1:0] pl_addr,
    input  logic [15:0]       pl_data,
    output logic              tx,
    output logic              halt,
    output logic [15:0]       halt_code
);

    localparam int               c_DIV_W    = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(UART_DIV - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // I/O register word offsets within the page (byte offset >> 1)
    localparam logic [6:0] c_OFS_UART_DATA = 7'h00;
    localparam logic [6:0] c_OFS_UART_STAT = 7'h01;
    localparam logic [6:0] c_OFS_CYCLE     = 7'h02;
    localparam logic [6:0] c_OFS_HALT      = 7'h03;

    logic [15:0]        r_mem [2**MEM_AW];

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_hold;
    logic               r_hold_full;
    logic               r_ovf;
    logic [15:0]        r_cycle;
    logic               r_halt;
    logic [15:0]        r_halt_code;

    logic               w_d_io;
    logic               w_i_io;
    logic [MEM_AW-1:0]  w_d_widx;
    logic [MEM_AW-1:0]  w_i_widx;
    logic               w_any_we;
    logic               w_ram_we;
    logic               w_io_we;
    logic [6:0]         w_io_ofs;
    logic               w_uart_wr;
    logic               w_stat_wr;
    logic               w_cycle_wr;
    logic               w_halt_wr;
    logic               w_busy;
    logic               w_bit_end;
    logic               w_stop_reload;
    logic [15:0]        w_stat;
    logic [15:0]        w_io_rdata;
    logic               w_tx;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_d_io     = (daddr[15:8] == IO_BASE[15:8]);
    assign w_i_io     = (iaddr[15:8] == IO_BASE[15:8]);
    assign w_d_widx   = daddr[MEM_AW:1];
    assign w_i_widx   = iaddr[MEM_AW:1];
    assign w_any_we   = dwe0 | dwe1;
    assign w_ram_we   = w_any_we & ~w_d_io;
    assign w_io_we    = w_any_we & w_d_io;
    assign w_io_ofs   = daddr[7:1];
    assign w_uart_wr  = w_io_we && (w_io_ofs == c_OFS_UART_DATA);
    assign w_stat_wr  = w_io_we && (w_io_ofs == c_OFS_UART_STAT);
    assign w_cycle_wr = w_io_we && (w_io_ofs == c_OFS_CYCLE);
    assign w_halt_wr  = w_io_we && (w_io_ofs == c_OFS_HALT);
    assign w_unused   = ^{daddr[0], iaddr[0]};

    // ------------------------------------------------------------------
    // Word RAM: preload wins over any CPU store in the same cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pl_we) begin
            r_mem[pl_addr] <= pl_data;
        end else if (w_ram_we) begin
            if (dwe0) begin
                r_mem[w_d_widx][15:8] <= ddout[15:8];
            end
            if (dwe1) begin
                r_mem[w_d_widx][7:0] <= ddout[7:0];
            end
        end
    end

    assign idin = (ioe && !w_i_io) ? r_mem[w_i_widx] : 16'h0000;

    assign w_busy = (r_state != c_ST_IDLE);
    assign w_stat = {13'b0, r_ovf, r_hold_full, w_busy};

    always_comb begin
        w_io_rdata = 16'h0000;
        case (w_io_ofs)
            c_OFS_UART_STAT: w_io_rdata = w_stat;
            c_OFS_CYCLE:     w_io_rdata = r_cycle;
            c_OFS_HALT:      w_io_rdata = r_halt_code;
            default:         w_io_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        ddin = 16'h0000;
        if (doe) begin
            ddin = w_d_io ? w_io_rdata : r_mem[w_d_widx];
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and halt register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle     <= 16'h0000;
            r_halt      <= 1'b0;
            r_halt_code <= 16'h0000;
        end else begin
            r_cycle <= w_cycle_wr ? ddout : r_cycle + 16'h0001;
            if (w_halt_wr) begin
                r_halt      <= 1'b1;
                r_halt_code <= ddout;
            end
        end
    end

    assign halt      = r_halt;
    assign halt_code = r_halt_code;

    // ------------------------------------------------------------------
    // UART transmitter FSM
    // ------------------------------------------------------------------
    assign w_bit_end     = (r_div == c_DIV_LAST);
    assign w_stop_reload = (r_state == c_ST_STOP) && w_bit_end && r_hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_uart_wr) w_state_nxt = c_ST_START;
            c_ST_START: if (w_bit_end) w_state_nxt = c_ST_DATA;
            c_ST_DATA:  if (w_bit_end && (r_bitcnt == 3'd7)) w_state_nxt = c_ST_STOP;
            c_ST_STOP:  if (w_bit_end) w_state_nxt = r_hold_full ? c_ST_START : c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            c_ST_START: w_tx = 1'b0;
            c_ST_DATA:  w_tx = r_shift[0];
            default:    w_tx = 1'b1;
        endcase
    end

    assign tx = w_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div       <= '0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_div <= ((r_state == c_ST_IDLE) || w_bit_end) ? '0 : r_div + 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_uart_wr) begin
                        r_shift <= ddout[7:0];
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_bitcnt <= 3'd0;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
                default: ;
            endcase
            // Frame boundary with a held byte: hand it over, a coincident write refills hold
            if (w_stop_reload) begin
                r_shift     <= r_hold;
                r_hold_full <= w_uart_wr;
                if (w_uart_wr) begin
                    r_hold <= ddout[7:0];
                end
            end else if (w_uart_wr && w_busy) begin
                if (r_hold_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_hold      <= ddout[7:0];
                    r_hold_full <= 1'b1;
                end
            end
            if (w_stat_wr) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_risc16_bus_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc16_bus_resp
//  Description : Directed self-checking bench for risc16_bus_resp.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_risc16_bus_resp;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] iaddr;
    logic        ioe;
    logic [15:0] idin;
    logic [15:0] daddr;
    logic        doe;
    logic        dwe0;
    logic        dwe1;
    logic [15:0] ddout;
    logic [15:0] ddin;
    logic        pl_we;
    logic [13:0] pl_addr;
    logic [15:0] pl_data;
    logic        tx;
    logic        halt;
    logic [15:0] halt_code;

    int n_total = 0;
    int n_bad   = 0;

    risc16_bus_resp #(
        .MEM_AW   (14),
        .IO_BASE  (16'hFF00),
        .UART_DIV (DIV)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .iaddr     (iaddr),
        .ioe       (ioe),
        .idin      (idin),
        .daddr     (daddr),
        .doe       (doe),
        .dwe0      (dwe0),
        .dwe1      (dwe1),
        .ddout     (ddout),
        .ddin      (ddin),
        .pl_we     (pl_we),
        .pl_addr   (pl_addr),
        .pl_data   (pl_data),
        .tx        (tx),
        .halt      (halt),
        .halt_code (halt_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ioe;
        logic [15:0] ia;
        logic        doe;
        logic        we0;
        logic        we1;
        logic [15:0] da;
        logic [15:0] wd;
        logic [15:0] exp_i;
        logic [15:0] exp_d;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ioe = 1'b0; iaddr = 16'h0; doe = 1'b0; dwe0 = 1'b0; dwe1 = 1'b0;
        daddr = 16'h0; ddout = 16'h0; pl_we = 1'b0; pl_addr = '0; pl_data = 16'h0;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        daddr = a; ddout = d; dwe0 = 1'b1; dwe1 = 1'b1;
        tick();
        dwe0 = 1'b0; dwe1 = 1'b0;
    endtask

    task automatic preload(input logic [13:0] a, input logic [15:0] d);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        tick();
        pl_we = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int c);
        int k;
        k = c / DIV;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        //            ioe  ia        doe  we0  we1  da        wd        exp_i     exp_d
        tbl[0]  = '{1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h000A, 16'h0000, 16'h1234, 16'h1234};
        tbl[1]  = '{1'b0, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h000B, 16'h0000, 16'h0000, 16'h1234};
        tbl[2]  = '{1'b1, 16'h000A, 1'b1, 1'b0, 1'b1, 16'h000B, 16'h00AB, 16'h1234, 16'h1234};
        tbl[3]  = '{1'b1, 16'h000B, 1'b1, 1'b0, 1'b0, 16'h000A, 16'h0000, 16'h12AB, 16'h12AB};
        tbl[4]  = '{1'b1, 16'hFF00, 1'b1, 1'b1, 1'b0, 16'h000A, 16'hCD00, 16'h0000, 16'h12AB};
        tbl[5]  = '{1'b1, 16'h000A, 1'b1, 1'b0, 1'b0, 16'h000A, 16'h0000, 16'hCDAB, 16'hCDAB};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h5A5A, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b1, 16'h8010, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5A5A, 16'h5A5A};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h0000, 16'h0000, 16'h5A5A};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFF0A, 16'h1111, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFF0A, 16'h0000, 16'h0000, 16'h0000};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFF06, 16'h0000, 16'h0000, 16'h0000};
        tbl[13] = '{1'b1, 16'hFF06, 1'b1, 1'b0, 1'b0, 16'hFF02, 16'h0000, 16'h0000, 16'h0000};

        idle_bus();
        rst = 1'b1;
        #1;
        check("reset_tx", {15'b0, tx}, 16'h0001);
        check("reset_halt", {15'b0, halt}, 16'h0000);
        check("reset_halt_code", halt_code, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        tick();

        preload(14'd5, 16'h1234);

        for (int i = 0; i < 14; i++) begin
            ioe = tbl[i].ioe; iaddr = tbl[i].ia; doe = tbl[i].doe;
            dwe0 = tbl[i].we0; dwe1 = tbl[i].we1; daddr = tbl[i].da; ddout = tbl[i].wd;
            #1;
            check($sformatf("vec%0d_idin", i), idin, tbl[i].exp_i);
            check($sformatf("vec%0d_ddin", i), ddin, tbl[i].exp_d);
            tick();
        end
        idle_bus();

        // Preload beats CPU stores in the same cycle, same word or not
        preload(14'd9, 16'h0909);
        pl_addr = 14'd8; pl_data = 16'h7777; pl_we = 1'b1;
        daddr = 16'h0012; ddout = 16'hFFFF; dwe0 = 1'b1; dwe1 = 1'b1;
        tick();
        pl_addr = 14'd9; pl_data = 16'h1357;
        tick();
        idle_bus();
        doe = 1'b1; daddr = 16'h0010; #1;
        check("pl_prio_w8", ddin, 16'h7777);
        daddr = 16'h0012; #1;
        check("pl_prio_w9", ddin, 16'h1357);
        idle_bus();

        // Cycle counter load and wrap
        io_write(16'hFF04, 16'hFFFE);
        doe = 1'b1; daddr = 16'hFF04;
        begin
            logic [15:0] cexp [4];
            cexp[0] = 16'hFFFE; cexp[1] = 16'hFFFF; cexp[2] = 16'h0000; cexp[3] = 16'h0001;
            for (int i = 0; i < 4; i++) begin
                #1;
                check($sformatf("cycle_%0d", i), ddin, cexp[i]);
                tick();
            end
        end
        idle_bus();

        // Single frame 0x55
        io_write(16'hFF00, 16'h0055);
        doe = 1'b1; daddr = 16'hFF02;
        for (int c = 0; c < 10 * DIV; c++) begin
            #1;
            check($sformatf("tx55_c%0d", c), {15'b0, tx}, {15'b0, frame_bit(8'h55, c)});
            check($sformatf("busy55_c%0d", c), ddin, 16'h0001);
            tick();
        end
        #1;
        check("tx55_idle", {15'b0, tx}, 16'h0001);
        check("stat55_idle", ddin, 16'h0000);
        idle_bus();

        // Back-to-back writes: hold, overflow, gapless second frame
        io_write(16'hFF00, 16'h0041);
        check("b2b_tx_c0", {15'b0, tx}, 16'h0000);
        io_write(16'hFF00, 16'h0042);
        doe = 1'b1; daddr = 16'hFF02; #1;
        check("b2b_stat_hold", ddin, 16'h0003);
        io_write(16'hFF00, 16'h0043);
        daddr = 16'hFF02; #1;
        check("b2b_stat_ovf", ddin, 16'h0007);
        for (int c = 2; c < 20 * DIV; c++) begin
            logic e;
            e = (c < 10 * DIV) ? frame_bit(8'h41, c) : frame_bit(8'h42, c - 10 * DIV);
            #1;
            check($sformatf("b2b_tx_c%0d", c), {15'b0, tx}, {15'b0, e});
            check($sformatf("b2b_busy_c%0d", c), {15'b0, ddin[0]}, 16'h0001);
            tick();
        end
        #1;
        check("b2b_stat_end", ddin, 16'h0004);
        io_write(16'hFF02, 16'h0000);
        daddr = 16'hFF02; doe = 1'b1; #1;
        check("b2b_stat_clr", ddin, 16'h0000);
        idle_bus();

        // Halt register
        io_write(16'hFF06, 16'hBEEF);
        #1;
        check("halt_set", {15'b0, halt}, 16'h0001);
        check("halt_code", halt_code, 16'hBEEF);
        doe = 1'b1; daddr = 16'hFF06; #1;
        check("halt_read", ddin, 16'hBEEF);
        io_write(16'hFF06, 16'h0042);
        #1;
        check("halt_sticky", {15'b0, halt}, 16'h0001);
        check("halt_code2", halt_code, 16'h0042);
        idle_bus();

        // Asynchronous reset mid-frame
        io_write(16'hFF00, 16'h00F0);
        tick();
        tick();
        #1;
        check("mid_tx_low", {15'b0, tx}, 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx", {15'b0, tx}, 16'h0001);
        check("arst_halt", {15'b0, halt}, 16'h0000);
        check("arst_halt_code", halt_code, 16'h0000);
        doe = 1'b1; daddr = 16'hFF02; #1;
        check("arst_stat", ddin, 16'h0000);
        daddr = 16'hFF04; #1;
        check("arst_cycle", ddin, 16'h0000);
        tick();
        rst = 1'b0;
        daddr = 16'h000A; #1;
        check("ram_kept", ddin, 16'hCDAB);
        tick();
        #1;
        check("idle_after_rst", {15'b0, tx}, 16'h0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
